// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg
//   Shared types and default constants for the seq_detect_ctrl block:
//   the controller state enum, default parameter values and the
//   reference 10101 pattern used by the fixed Mealy detectors.
package seq_ctrl_pkg;

    localparam int PAT_W_DEF = 5;   // pattern length in bits
    localparam int WIN_W_DEF = 8;   // window bit-counter width
    localparam int CNT_W_DEF = 4;   // match-counter width

    localparam logic [4:0] DEFAULT_PATTERN = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_detect_ctrl_match.sv
// seq_match_core
//   Serial pattern matcher: keeps the last PAT_W-1 accepted bits and a fill
//   counter, and flags a match combinationally when the incoming bit
//   completes the pattern. In non-overlapping mode a match empties the fill
//   counter so the next match needs PAT_W fresh bits; in overlapping mode
//   the history keeps counting towards the next match.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   clear    in   empty history and fill counter (controller ARM state)
//   shift    in   accept din this cycle
//   din      in   serial data bit
//   pattern  in   PAT_W  pattern, MSB is the oldest bit
//   overlap  in   1 = overlapping detection
//   match    out  din completes the pattern this cycle (Mealy)
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int                FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  history;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    // Oldest history bit lands in the pattern MSB, the live bit in the LSB.
    assign window = {history, din};
    assign match  = shift && (fill == FILL_FULL) && (window == pattern);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            history <= '0;
            fill    <= '0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= window[PAT_W-2:0];
            if (match && !overlap) begin
                fill <= '0;
            end else if (fill != FILL_FULL) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Sequencing layer around seq_match_core. A start request arms the
//   matcher (configuration latched, counters cleared), then the matcher runs
//   over cfg_window valid bits, counting detections. At window end the count
//   and the sticky threshold flag are held with done until the next start.
//
//   Build option SEQ_EARLY_STOP_EN: when defined, reaching the threshold
//   ends the run at that bit instead of consuming the whole window.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   din           in   serial data bit
//   din_valid     in   din is a new bit this cycle
//   start         in   single-cycle run request (honoured in IDLE and DONE)
//   cfg_pattern   in   PAT_W  pattern, MSB received first
//   cfg_overlap   in   1 = overlapping detection
//   cfg_window    in   WIN_W  valid bits per run
//   cfg_thresh    in   CNT_W  match threshold, 0 disables
//   busy          out  high in ARM and RUN
//   seq_detected  out  Mealy detect pulse
//   match_count   out  CNT_W  matches in the current or last run
//   thresh_hit    out  sticky threshold reached
//   done          out  run complete, held until next start
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             start,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic [CNT_W-1:0] cfg_thresh,
    output logic             busy,
    output logic             seq_detected,
    output logic [CNT_W-1:0] match_count,
    output logic             thresh_hit,
    output logic             done
);

    state_t state, state_next;

    // Shadow configuration, loaded in ARM so the run is isolated from cfg_*.
    logic [PAT_W-1:0] pattern_q;
    logic             overlap_q;
    logic [WIN_W-1:0] window_q;
    logic [CNT_W-1:0] thresh_q;

    logic [WIN_W-1:0] bit_cnt;
    logic [CNT_W-1:0] count_inc;
    logic             arming;
    logic             accept;
    logic             match;
    logic             last_bit;
    logic             thresh_set;
    logic             stop;

    assign arming = (state == ARM);
    assign accept = (state == RUN) && din_valid;

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (arming),
        .shift   (accept),
        .din     (din),
        .pattern (pattern_q),
        .overlap (overlap_q),
        .match   (match)
    );

    assign seq_detected = match;

    // Saturating increment; thresh_set compares the post-increment value so
    // the flag rises on the edge that makes the count equal the threshold.
    assign count_inc  = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    assign thresh_set = match && (thresh_q != '0) && (count_inc == thresh_q);
    assign last_bit   = accept && ((bit_cnt + WIN_W'(1)) == window_q);

`ifdef SEQ_EARLY_STOP_EN
    assign stop = last_bit || thresh_set;
`else
    assign stop = last_bit;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ARM;
            end
            ARM: begin
                busy = 1'b1;
                // Decided on the value being latched this cycle.
                state_next = (cfg_window == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (stop) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = ARM;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the shadow registers are reset too, even though ARM always
        // reloads them, so the block leaves reset in a fully known state.
        if (reset) begin
            pattern_q   <= '0;
            overlap_q   <= 1'b0;
            window_q    <= '0;
            thresh_q    <= '0;
            bit_cnt     <= '0;
            match_count <= '0;
            thresh_hit  <= 1'b0;
        end else if (arming) begin
            pattern_q   <= cfg_pattern;
            overlap_q   <= cfg_overlap;
            window_q    <= cfg_window;
            thresh_q    <= cfg_thresh;
            bit_cnt     <= '0;
            match_count <= '0;
            thresh_hit  <= 1'b0;
        end else if (accept) begin
            bit_cnt <= bit_cnt + WIN_W'(1);
            if (match) match_count <= count_inc;
            if (thresh_set) thresh_hit <= 1'b1;
        end
    end

endmodule
